// File: rtl/nibble_serial_adder.sv
// Serial multi-nibble adder: one shared 4-bit ripple slice of full_adder cells processes one nibble per clock.
// Optional feature macro: NIBBLE_SUB_EN adds the op port (op=1 computes A-B as A + ~B + 1).
module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic ci_i,
  output logic s_o,
  output logic co_o
);
  assign s_o  = a_i ^ b_i ^ ci_i;
  assign co_o = (a_i & b_i) | (ci_i & (a_i ^ b_i));
endmodule

module nibble_serial_adder #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [4*NIBBLES-1:0] A,
  input  logic [4*NIBBLES-1:0] B,
`ifdef NIBBLE_SUB_EN
  input  logic                 op,
`endif
  output logic                 busy,
  output logic                 done,
  output logic [4*NIBBLES-1:0] sum,
  output logic                 co
);
  localparam int W  = 4 * NIBBLES;
  localparam int CW = $clog2(NIBBLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q;
  logic [W-1:0]  a_q;
  logic [W-1:0]  b_q;
  logic [W-1:0]  sum_q;
  logic [CW-1:0] cnt_q;
  logic          c_q;
  logic          co_q;
  logic          busy_q;
  logic          done_q;
  logic [CW+1:0] base_s;
  logic [3:0]    a_nib_s;
  logic [3:0]    b_nib_s;
  logic [3:0]    slice_sum_s;
  logic [4:0]    carry_s;
`ifdef NIBBLE_SUB_EN
  logic          op_q;
`endif

  // Bit offset of the nibble currently being processed.
  assign base_s  = {cnt_q, 2'b00};
  assign a_nib_s = a_q[base_s +: 4];
`ifdef NIBBLE_SUB_EN
  assign b_nib_s = b_q[base_s +: 4] ^ {4{op_q}};
`else
  assign b_nib_s = b_q[base_s +: 4];
`endif
  assign carry_s[0] = c_q;

  for (genvar i = 0; i < 4; i++) begin : g_fa
    full_adder u_fa (
      .a_i  (a_nib_s[i]),
      .b_i  (b_nib_s[i]),
      .ci_i (carry_s[i]),
      .s_o  (slice_sum_s[i]),
      .co_o (carry_s[i+1])
    );
  end

  // Control FSM with registered operands, carry chain and outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      c_q     <= 1'b0;
      co_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef NIBBLE_SUB_EN
      op_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q     <= A;
            b_q     <= B;
            sum_q   <= '0;
            cnt_q   <= '0;
`ifdef NIBBLE_SUB_EN
            op_q    <= op;
            c_q     <= op;
`else
            c_q     <= 1'b0;
`endif
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          sum_q[base_s +: 4] <= slice_sum_s;
          c_q                <= carry_s[4];
          // The counter parks on the last nibble so it never leaves 0..NIBBLES-1.
          if (cnt_q == CNT_LAST) begin
            co_q    <= carry_s[4];
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            cnt_q   <= cnt_q + CW'(1);
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign co   = co_q;
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed self-checking bench for nibble_serial_adder (NIBBLES=4, 16-bit operands).
module tb_nibble_serial_adder;
  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] A     = 16'h0000;
  logic [15:0] B     = 16'h0000;
`ifdef NIBBLE_SUB_EN
  logic        op    = 1'b0;
`endif
  logic        busy;
  logic        done;
  logic [15:0] sum;
  logic        co;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  nibble_serial_adder #(.NIBBLES(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .A     (A),
    .B     (B),
`ifdef NIBBLE_SUB_EN
    .op    (op),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .co    (co)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete operation: accept, three quiet RUN edges, done pulse, return to idle.
  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic o, input logic [15:0] es, input logic ec, input logic prev_co);
    A     = a;
    B     = b;
    start = 1'b1;
`ifdef NIBBLE_SUB_EN
    op    = o;
`endif
    tick();
    start = 1'b0;
    chk({tag, "_busy_acc"}, {15'd0, busy}, 16'd1);
    chk({tag, "_sum_clr"}, sum, 16'h0000);
    chk({tag, "_co_hold"}, {15'd0, co}, {15'd0, prev_co});
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk({tag, "_done_early"}, {15'd0, done}, 16'd0);
    end
    tick();
    chk({tag, "_done"}, {15'd0, done}, 16'd1);
    chk({tag, "_busy_done"}, {15'd0, busy}, 16'd1);
    chk({tag, "_sum"}, sum, es);
    chk({tag, "_co"}, {15'd0, co}, {15'd0, ec});
    tick();
    chk({tag, "_done_end"}, {15'd0, done}, 16'd0);
    chk({tag, "_busy_end"}, {15'd0, busy}, 16'd0);
    chk({tag, "_sum_keep"}, sum, es);
    chk({tag, "_co_keep"}, {15'd0, co}, {15'd0, ec});
  endtask

  initial begin
    // Power-on reset.
    #12;
    chk("rst_busy", {15'd0, busy}, 16'd0);
    chk("rst_done", {15'd0, done}, 16'd0);
    chk("rst_sum", sum, 16'h0000);
    chk("rst_co", {15'd0, co}, 16'd0);
    rst_n = 1'b1;
    tick();
    // Reset while idle, then no spontaneous done.
    rst_n = 1'b0;
    #2;
    chk("rst2_busy", {15'd0, busy}, 16'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("idle_no_done", {15'd0, done}, 16'd0);
      chk("idle_no_busy", {15'd0, busy}, 16'd0);
    end

    run_op("ripple", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_op("basic", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b1);
    run_op("msb", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_op("mix", 16'hA5C3, 16'h1F2E, 1'b0, 16'hC4F1, 1'b0, 1'b1);

    // Start while busy is dropped.
    A = 16'h0F0F;
    B = 16'h0101;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    A = 16'hFFFF;
    B = 16'hFFFF;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("busy_drop_done", {15'd0, done}, 16'd1);
    chk("busy_drop_sum", sum, 16'h1010);
    chk("busy_drop_co", {15'd0, co}, 16'd0);
    tick();
    chk("busy_drop_done_end", {15'd0, done}, 16'd0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("busy_drop_no_second", {15'd0, done | busy}, 16'd0);
    end

    // Reset mid-RUN aborts immediately.
    A = 16'h1111;
    B = 16'h2222;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("midrun_busy_pre", {15'd0, busy}, 16'd1);
    rst_n = 1'b0;
    #1;
    chk("midrun_sum", sum, 16'h0000);
    chk("midrun_busy", {15'd0, busy}, 16'd0);
    chk("midrun_done", {15'd0, done}, 16'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("midrun_idle", {15'd0, busy}, 16'd0);
    run_op("after_rst", 16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0, 1'b0);

`ifdef NIBBLE_SUB_EN
    run_op("sub_neg", 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    run_op("sub_pos", 16'h0007, 16'h0005, 1'b1, 16'h0002, 1'b1, 1'b0);
    run_op("add_op0", 16'h0007, 16'h0005, 1'b0, 16'h000C, 1'b0, 1'b1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
